// File: rtl/bus_cmd_pkg.sv
// Shared types and default parameters for the bus command master.
// Optional timeout support is enabled with the BUS_CMD_MASTER_TIMEOUT_EN macro.
package bus_cmd_pkg;

    localparam int DEF_AW      = 8;
    localparam int DEF_DW      = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/bus_cmd_fifo.sv
// Synchronous FIFO holding queued bus commands; DEPTH must be a power of two.
// Push is ignored when full and pop is ignored when empty.
module bus_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_dout    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_cmd_master.sv
// Queues read/write commands and issues them one at a time on a req/gnt bus.
// Define BUS_CMD_MASTER_TIMEOUT_EN to abort requests left ungranted for TIMEOUT cycles.
module bus_cmd_master
    import bus_cmd_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic          rsp_wr,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          busy,
    output logic          bus_req,
    output logic          bus_wr_en,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_gnt,
    input  logic [DW-1:0] bus_rdata,
    output state_t        dbg_state
);

    // Handshake: a command is taken on any edge where cmd_valid && cmd_ready;
    // rsp_valid is a single-cycle pulse with no backpressure.
    localparam int FW = 1 + AW + DW;

    state_t        r_state;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic [FW-1:0] w_head;

    assign cmd_ready = ~w_full;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign busy      = !w_empty || (r_state != ST_IDLE);
    assign dbg_state = r_state;

    bus_cmd_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid & ~w_full),
        .i_pop   (w_pop),
        .i_din   ({cmd_wr, cmd_addr, cmd_wdata}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef BUS_CMD_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_rsp_err;
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_wr_en <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
`ifdef BUS_CMD_MASTER_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_rsp_err <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        bus_wr_en <= w_head[FW-1];
                        bus_addr  <= w_head[DW +: AW];
                        bus_wdata <= w_head[DW-1:0];
                        bus_req   <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // bus_wr_en still describes the in-flight command here.
                    if (bus_gnt) begin
                        rsp_valid <= 1'b1;
                        rsp_wr    <= bus_wr_en;
                        rsp_rdata <= bus_wr_en ? '0 : bus_rdata;
                        bus_req   <= 1'b0;
                        bus_wr_en <= 1'b0;
                        r_state   <= ST_GAP;
`ifdef BUS_CMD_MASTER_TIMEOUT_EN
                        r_rsp_err <= 1'b0;
                        r_tmo_cnt <= '0;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_wr    <= bus_wr_en;
                        rsp_rdata <= '0;
                        r_rsp_err <= 1'b1;
                        bus_req   <= 1'b0;
                        bus_wr_en <= 1'b0;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_GAP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed self-checking bench for bus_cmd_master (timeout test needs BUS_CMD_MASTER_TIMEOUT_EN).
module tb_bus_cmd_master;
  import bus_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        bus_req;
  logic        bus_wr_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic [31:0] bus_rdata;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [40:0] exp_q[$];

  bus_cmd_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_wr    (rsp_wr),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .bus_req   (bus_req),
    .bus_wr_en (bus_wr_en),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_gnt   (bus_gnt),
    .bus_rdata (bus_rdata),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at a negedge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus_req && n < 40) begin
      tick();
      n++;
    end
    check(tag, 64'(bus_req), 64'd1);
  endtask

  task automatic grant(input logic [31:0] rd);
    bus_gnt   = 1'b1;
    bus_rdata = rd;
    tick();
    bus_gnt   = 1'b0;
    bus_rdata = 32'hA5A5_5A5A;
  endtask

  initial begin
    logic [40:0] e;
    logic        seen;
    int          n;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    bus_gnt   = 1'b0;
    bus_rdata = 32'hA5A5_5A5A;
    tick();
    tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_bus_req",   64'(bus_req),   64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_bus_addr",  64'(bus_addr),  64'd0);
    check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();

    // write, grant three cycles after request
    push_cmd(1'b1, 8'h10, 32'hDEAD_BEEF);
    check("wr_lat_e", 64'(bus_req), 64'd0);
    tick();
    check("wr_lat_e1", 64'(bus_req),   64'd1);
    check("wr_wr_en",  64'(bus_wr_en), 64'd1);
    check("wr_addr",   64'(bus_addr),  64'h10);
    check("wr_wdata",  64'(bus_wdata), 64'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wr_hold_req",  64'(bus_req),   64'd1);
      check("wr_hold_addr", 64'(bus_addr),  64'h10);
      check("wr_hold_rsp",  64'(rsp_valid), 64'd0);
    end
    grant(32'h0BAD_F00D);
    check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("wr_rsp_wr",    64'(rsp_wr),    64'd1);
    check("wr_rsp_err",   64'(rsp_err),   64'd0);
    check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("wr_req_drop",  64'(bus_req),   64'd0);
    check("wr_en_drop",   64'(bus_wr_en), 64'd0);
    tick();
    check("wr_rsp_pulse", 64'(rsp_valid), 64'd0);
    check("wr_rsp_hold",  64'(rsp_wr),    64'd1);
    check("wr_gap_req",   64'(bus_req),   64'd0);
    tick();
    tick();

    // read
    push_cmd(1'b0, 8'h20, 32'hFFFF_FFFF);
    tick();
    check("rd_req",   64'(bus_req),   64'd1);
    check("rd_wr_en", 64'(bus_wr_en), 64'd0);
    check("rd_addr",  64'(bus_addr),  64'h20);
    grant(32'h1234_5678);
    check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    check("rd_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
    check("rd_rsp_wr",    64'(rsp_wr),    64'd0);
    check("rd_rsp_err",   64'(rsp_err),   64'd0);
    tick();
    check("rd_rsp_pulse", 64'(rsp_valid), 64'd0);
    check("rd_rdata_hold", 64'(rsp_rdata), 64'h1234_5678);
    tick();
    tick();

    // fill: 1 in flight + 4 buffered, sixth offer rejected, then FIFO order
    for (int i = 0; i < 5; i++) begin
      check("fill_ready", 64'(cmd_ready), 64'd1);
      push_cmd(1'b1, 8'(8'h30 + i), 32'h1000 + 32'(i));
      exp_q.push_back({1'b1, 8'(8'h30 + i), 32'h1000 + 32'(i)});
    end
    check("full_ready", 64'(cmd_ready), 64'd0);
    check("full_busy",  64'(busy),      64'd1);
    push_cmd(1'b0, 8'h3F, 32'h3F3F_3F3F);
    check("full_ready2", 64'(cmd_ready), 64'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_req("ord_req");
      check("ord_addr",  64'(bus_addr),  64'(e[39:32]));
      check("ord_wdata", 64'(bus_wdata), 64'(e[31:0]));
      check("ord_wr",    64'(bus_wr_en), 64'(e[40]));
      grant(32'h0);
      check("ord_rsp",     64'(rsp_valid), 64'd1);
      check("ord_rsp_err", 64'(rsp_err),   64'd0);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_req) seen = 1'b1;
    end
    check("drop_sixth", 64'(seen), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);

    // back-to-back writes with grant held high
    push_cmd(1'b1, 8'h50, 32'h5050);
    push_cmd(1'b1, 8'h51, 32'h5151);
    check("b2b_req0", 64'(bus_req), 64'd1);
    bus_gnt = 1'b1;
    tick();
    check("b2b_g_req", 64'(bus_req),   64'd0);
    check("b2b_g_rsp", 64'(rsp_valid), 64'd1);
    tick();
    check("b2b_g1_req", 64'(bus_req),   64'd0);
    check("b2b_g1_rsp", 64'(rsp_valid), 64'd0);
    tick();
    check("b2b_g2_req",  64'(bus_req),  64'd1);
    check("b2b_g2_addr", 64'(bus_addr), 64'h51);
    tick();
    check("b2b_2_rsp", 64'(rsp_valid), 64'd1);
    check("b2b_2_req", 64'(bus_req),   64'd0);
    tick();
    check("b2b_ign_gnt", 64'(rsp_valid), 64'd0);
    bus_gnt = 1'b0;
    tick();
    check("b2b_busy", 64'(busy), 64'd0);

    // reset two edges into REQ with three commands queued
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b0, 8'(8'h60 + i), 32'h0);
    end
    check("rr_req",  64'(bus_req), 64'd1);
    check("rr_busy", 64'(busy),    64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_bus_req",   64'(bus_req),   64'd0);
    check("rr_busy0",     64'(busy),      64'd0);
    check("rr_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rr_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rr_state",     64'(dbg_state), 64'(ST_IDLE));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid || bus_req) seen = 1'b1;
    end
    check("rr_quiet", 64'(seen), 64'd0);

`ifdef BUS_CMD_MASTER_TIMEOUT_EN
    // timeout, then the queued command issues after GAP
    push_cmd(1'b0, 8'h70, 32'h0);
    tick();
    check("to_req", 64'(bus_req), 64'd1);
    n = 1;
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 8'h71;
    cmd_wdata = 32'h7171;
    while (n < 40) begin
      tick();
      cmd_valid = 1'b0;
      if (!bus_req) break;
      n++;
    end
    check("to_req_cycles", 64'(n),         64'd16);
    check("to_rsp_valid",  64'(rsp_valid), 64'd1);
    check("to_rsp_err",    64'(rsp_err),   64'd1);
    check("to_rsp_rdata",  64'(rsp_rdata), 64'd0);
    tick();
    check("to_gap_req", 64'(bus_req), 64'd0);
    tick();
    check("to_next_req",  64'(bus_req),  64'd1);
    check("to_next_addr", 64'(bus_addr), 64'h71);
    grant(32'h0);
    check("to_next_rsp", 64'(rsp_valid), 64'd1);
    check("to_next_err", 64'(rsp_err),   64'd0);
    tick();
    tick();
`else
    n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
